// File: rtl/riscv_base_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_base_divider_pkg
// Purpose  : Shared RV32M divide/remainder match constants and a small
//            decode helper used by the divider and its bench.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_base_divider_pkg;

  // Instruction match values and the field masks they are compared under
  localparam logic [31:0] INST_DIV       = 32'h0200_4033;
  localparam logic [31:0] INST_DIV_MASK  = 32'hFE00_707F;
  localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
  localparam logic [31:0] INST_DIVU_MASK = 32'hFE00_707F;
  localparam logic [31:0] INST_REM       = 32'h0200_6033;
  localparam logic [31:0] INST_REM_MASK  = 32'hFE00_707F;
  localparam logic [31:0] INST_REMU      = 32'h0200_7033;
  localparam logic [31:0] INST_REMU_MASK = 32'hFE00_707F;

  localparam int unsigned DATA_W = 32;

  // Decoded view of an instruction word as far as the divider cares
  typedef struct packed {
    logic is_div;     // one of DIV/DIVU/REM/REMU
    logic is_signed;  // DIV or REM
    logic is_rem;     // REM or REMU
  } div_decode_t;

  function automatic div_decode_t div_decode(input logic [31:0] inst);
    div_decode_t d;
    logic        m_div;
    logic        m_divu;
    logic        m_rem;
    logic        m_remu;
    m_div       = (inst & INST_DIV_MASK)  == INST_DIV;
    m_divu      = (inst & INST_DIVU_MASK) == INST_DIVU;
    m_rem       = (inst & INST_REM_MASK)  == INST_REM;
    m_remu      = (inst & INST_REMU_MASK) == INST_REMU;
    d.is_div    = m_div | m_divu | m_rem | m_remu;
    d.is_signed = m_div | m_rem;
    d.is_rem    = m_rem | m_remu;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_base_divider.sv
`default_nettype none
// ============================================================================
// Module   : riscv_base_divider
// Purpose  : Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
//            One quotient bit per cycle, MSB first; single-cycle writeback
//            strobe with a held result register.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_base_divider
  import riscv_base_divider_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [31:0] opcode_opcode_i,
  input  logic [31:0] opcode_pc_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [4:0]  opcode_ra_idx_i,
  input  logic [4:0]  opcode_rb_idx_i,
  input  logic [31:0] opcode_ra_operand_i,
  input  logic [31:0] opcode_rb_operand_i,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o
);

  div_decode_t w_dec;
  logic        w_start;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_invert;

  logic        r_busy;
  logic        r_rem_sel;
  logic        r_invert;
  logic [31:0] r_dvd;     // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] r_dvs;     // divisor magnitude
  logic [31:0] r_rem;     // partial remainder
  logic [31:0] r_mask;    // one-hot marker of the quotient bit being produced
  logic        r_wb_valid;
  logic [31:0] r_wb_value;

  logic [33:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_res_raw;
  logic [31:0] w_result;
  logic        w_unused_ok;

  assign w_dec   = div_decode(opcode_opcode_i);
  assign w_start = opcode_valid_i & ~opcode_invalid_i & w_dec.is_div & ~r_busy;

  // Operand magnitudes; unsigned ops pass the raw value through
  assign w_mag_a = (w_dec.is_signed && opcode_ra_operand_i[31]) ? (32'd0 - opcode_ra_operand_i)
                                                                : opcode_ra_operand_i;
  assign w_mag_b = (w_dec.is_signed && opcode_rb_operand_i[31]) ? (32'd0 - opcode_rb_operand_i)
                                                                : opcode_rb_operand_i;

  // Remainder follows the dividend sign; a zero divisor leaves the all-ones
  // quotient un-negated so DIV by zero yields -1 as the ISA requires
  assign w_invert = w_dec.is_signed &
                    (w_dec.is_rem ? opcode_ra_operand_i[31]
                                  : ((opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]) &
                                     (opcode_rb_operand_i != 32'd0)));

  // Trial subtract of the divisor from the shifted partial remainder; bit 33
  // is the borrow, which means the divisor did not fit
  assign w_diff     = {1'b0, r_rem, r_dvd[31]} - {2'b00, r_dvs};
  assign w_qbit     = ~w_diff[33];
  assign w_rem_next = w_qbit ? w_diff[31:0] : {r_rem[30:0], r_dvd[31]};

  assign w_res_raw  = r_rem_sel ? r_rem : r_dvd;
  assign w_result   = r_invert ? (32'd0 - w_res_raw) : w_res_raw;

  // Index/pc fields are carried by the issue bus but play no part here;
  // w_diff[32] is always zero whenever the subtract result is kept
  assign w_unused_ok = ^{opcode_pc_i, opcode_rd_idx_i, opcode_ra_idx_i,
                         opcode_rb_idx_i, w_diff[32]};

  // Capture operands on start, iterate while the mask is live, then publish
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_busy     <= 1'b0;
      r_rem_sel  <= 1'b0;
      r_invert   <= 1'b0;
      r_dvd      <= 32'd0;
      r_dvs      <= 32'd0;
      r_rem      <= 32'd0;
      r_mask     <= 32'd0;
      r_wb_valid <= 1'b0;
      r_wb_value <= 32'd0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_start) begin
        r_busy    <= 1'b1;
        r_rem_sel <= w_dec.is_rem;
        r_invert  <= w_invert;
        r_dvd     <= w_mag_a;
        r_dvs     <= w_mag_b;
        r_rem     <= 32'd0;
        r_mask    <= 32'h8000_0000;
      end else if (r_busy) begin
        if (r_mask != 32'd0) begin
          r_dvd  <= {r_dvd[30:0], w_qbit};
          r_rem  <= w_rem_next;
          r_mask <= r_mask >> 1;
        end else begin
          r_busy     <= 1'b0;
          r_wb_valid <= 1'b1;
          r_wb_value <= w_result;
        end
      end
    end
  end

  assign writeback_valid_o = r_wb_valid;
  assign writeback_value_o = r_wb_value;

endmodule
`default_nettype wire

// File: tb/tb_riscv_base_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_base_divider
// Purpose  : Self-checking bench for riscv_base_divider: directed RV32M
//            corner cases, control scenarios and randomized operations
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_base_divider;
  import riscv_base_divider_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        opcode_valid_i = 1'b0;
  logic [31:0] opcode_opcode_i = 32'd0;
  logic [31:0] opcode_pc_i = 32'd0;
  logic        opcode_invalid_i = 1'b0;
  logic [4:0]  opcode_rd_idx_i = 5'd0;
  logic [4:0]  opcode_ra_idx_i = 5'd0;
  logic [4:0]  opcode_rb_idx_i = 5'd0;
  logic [31:0] opcode_ra_operand_i = 32'd0;
  logic [31:0] opcode_rb_operand_i = 32'd0;
  logic        writeback_valid_o;
  logic [31:0] writeback_value_o;

  int checks = 0;
  int errors = 0;

  localparam int OP_DIV  = 0;
  localparam int OP_DIVU = 1;
  localparam int OP_REM  = 2;
  localparam int OP_REMU = 3;

  riscv_base_divider dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .opcode_valid_i      (opcode_valid_i),
    .opcode_opcode_i     (opcode_opcode_i),
    .opcode_pc_i         (opcode_pc_i),
    .opcode_invalid_i    (opcode_invalid_i),
    .opcode_rd_idx_i     (opcode_rd_idx_i),
    .opcode_ra_idx_i     (opcode_ra_idx_i),
    .opcode_rb_idx_i     (opcode_rb_idx_i),
    .opcode_ra_operand_i (opcode_ra_operand_i),
    .opcode_rb_operand_i (opcode_rb_operand_i),
    .writeback_valid_o   (writeback_valid_o),
    .writeback_value_o   (writeback_value_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: ISA semantics via wide arithmetic, with the two ISA-defined
  // divide-by-zero results stated directly
  function automatic logic [31:0] ref_model(input int op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    bit     sgn;
    bit     rem;
    sgn = (op == OP_DIV) || (op == OP_REM);
    rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    return rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  // Encode an op, scrambling the register fields the decode must ignore
  function automatic logic [31:0] make_inst(input int op);
    logic [31:0] base;
    case (op)
      OP_DIV:  base = INST_DIV;
      OP_DIVU: base = INST_DIVU;
      OP_REM:  base = INST_REM;
      default: base = INST_REMU;
    endcase
    return base | ($urandom & ~INST_DIV_MASK);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_unused();
    opcode_pc_i     = $urandom;
    opcode_rd_idx_i = 5'($urandom);
    opcode_ra_idx_i = 5'($urandom);
    opcode_rb_idx_i = 5'($urandom);
  endtask

  // Issue one op, check latency, result and that the result holds afterwards.
  // With poke set, a different DIV is presented while the unit is busy.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke);
    logic [31:0] exp;
    int          lat;
    exp = ref_model(op, a, b);
    randomize_unused();
    opcode_opcode_i     = make_inst(op);
    opcode_ra_operand_i = a;
    opcode_rb_operand_i = b;
    opcode_valid_i      = 1'b1;
    @(posedge clk_i); #1;
    opcode_valid_i      = 1'b0;
    opcode_ra_operand_i = $urandom;
    opcode_rb_operand_i = $urandom;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 5) begin
        opcode_opcode_i     = make_inst(OP_DIV);
        opcode_ra_operand_i = 32'd100;
        opcode_rb_operand_i = 32'd7;
        opcode_valid_i      = 1'b1;
      end
      @(posedge clk_i); #1;
      opcode_valid_i = 1'b0;
      if (writeback_valid_o) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_value"}, writeback_value_o, exp);
    @(posedge clk_i); #1;
    check({tag, "_strobe_drop"}, {31'd0, writeback_valid_o}, 32'd0);
    check({tag, "_hold1"}, writeback_value_o, exp);
    @(posedge clk_i); #1;
    check({tag, "_hold2"}, writeback_value_o, exp);
  endtask

  // Count strobes over a window; the caller states how many it expects
  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (writeback_valid_o) n++;
    end
  endtask

  initial begin
    int          n;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prev;

    // Reset state, visible before any clock edge
    #2;
    check("reset_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("reset_value", writeback_value_o, 32'd0);
    #10 rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Signed quotient quadrants
    run_op(OP_DIV, 32'd20,        32'd3,        "div_pp", 1'b0);
    run_op(OP_DIV, -32'sd20,      32'd3,        "div_np", 1'b0);
    run_op(OP_DIV, 32'd20,        -32'sd3,      "div_pn", 1'b0);
    run_op(OP_DIV, -32'sd20,      -32'sd3,      "div_nn", 1'b0);
    run_op(OP_DIV, 32'd100,       32'd10,       "div_100_10", 1'b0);
    // Remainder takes the dividend sign
    run_op(OP_REM, 32'd20,        32'd3,        "rem_pp", 1'b0);
    run_op(OP_REM, -32'sd20,      32'd3,        "rem_np", 1'b0);
    run_op(OP_REM, 32'd20,        -32'sd3,      "rem_pn", 1'b0);
    run_op(OP_REM, -32'sd20,      -32'sd3,      "rem_nn", 1'b0);
    run_op(OP_REM, 32'd100,       32'd10,       "rem_100_10", 1'b0);
    // Unsigned
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2,         "divu_max_2", 1'b0);
    run_op(OP_DIVU, 32'h8000_0000, 32'h4000_0000, "divu_msb", 1'b0);
    run_op(OP_DIVU, 32'h1000_0000, 32'h0000_1000, "divu_shift", 1'b0);
    run_op(OP_REMU, 32'h8000_0001, 32'd2,         "remu_odd", 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_maxmax", 1'b0);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "remu_maxmax", 1'b0);
    // Divide by zero and zero dividend
    run_op(OP_DIV,  32'd10, 32'd0, "div_by0", 1'b0);
    run_op(OP_DIVU, 32'd10, 32'd0, "divu_by0", 1'b0);
    run_op(OP_REM,  32'd10, 32'd0, "rem_by0", 1'b0);
    run_op(OP_REMU, 32'd10, 32'd0, "remu_by0", 1'b0);
    run_op(OP_DIV,  -32'sd10, 32'd0, "div_neg_by0", 1'b0);
    run_op(OP_REM,  -32'sd10, 32'd0, "rem_neg_by0", 1'b0);
    run_op(OP_DIV,  32'd0, 32'd5, "div_zero", 1'b0);
    run_op(OP_DIVU, 32'd0, 32'd5, "divu_zero", 1'b0);
    run_op(OP_REM,  32'd0, 32'd5, "rem_zero", 1'b0);
    run_op(OP_REMU, 32'd0, 32'd5, "remu_zero", 1'b0);
    // Signed overflow
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
    run_op(OP_DIV, 32'h7FFF_FFFF, 32'd2,         "div_maxpos", 1'b0);

    // A valid while busy must not disturb the running op or add a strobe
    run_op(OP_DIVU, 32'd1000, 32'd9, "busy_poke", 1'b1);
    count_strobes(40, n);
    check("busy_poke_no_extra", 32'(n), 32'd0);

    // Non-divide opcodes (MUL, ADD) and an invalid-flagged DIV never start
    prev = writeback_value_o;
    opcode_ra_operand_i = 32'd77;
    opcode_rb_operand_i = 32'd3;
    opcode_opcode_i = 32'h0200_0033; opcode_valid_i = 1'b1;
    @(posedge clk_i); #1;
    opcode_opcode_i = 32'h0000_0033;
    @(posedge clk_i); #1;
    opcode_opcode_i = make_inst(OP_DIV); opcode_invalid_i = 1'b1;
    @(posedge clk_i); #1;
    opcode_valid_i = 1'b0; opcode_invalid_i = 1'b0;
    count_strobes(40, n);
    check("nondiv_no_strobe", 32'(n), 32'd0);
    check("nondiv_value_held", writeback_value_o, prev);

    // Reset in the middle of a division aborts it and clears the result
    opcode_opcode_i = make_inst(OP_DIV);
    opcode_ra_operand_i = 32'd1234;
    opcode_rb_operand_i = 32'd5;
    opcode_valid_i = 1'b1;
    @(posedge clk_i); #1;
    opcode_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_valid", {31'd0, writeback_valid_o}, 32'd0);
    check("midrst_value", writeback_value_o, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b1;
    count_strobes(40, n);
    check("midrst_no_strobe", 32'(n), 32'd0);

    // Randomized ops, biased toward zero / small / all-ones divisors
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
